// File: rtl/mem_cmd_sched_if.sv
// Signal bundle between the clk150 command/data FIFOs, the command scheduler and the memory controller.
// The stat_* counter signals exist only when MEM_CMD_SCHED_STATS_EN is defined.
interface mem_cmd_sched_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 13,
    parameter int DATA_W = 32
);
    localparam int CMD_W = ADDR_W + LEN_W;

    logic [CMD_W-1:0]  rd_cmd_data;
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [CMD_W-1:0]  wr_cmd_data;
    logic              wr_cmd_valid;
    logic              wr_cmd_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_valid;
    logic              wr_data_ready;
    logic [CMD_W:0]    mem_cmd_data;
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_valid;
    logic              mem_wr_last;
    logic              mem_wr_ready;
    logic              mem_rd_done;
    logic [3:0]        rd_outstanding;
`ifdef MEM_CMD_SCHED_STATS_EN
    logic [31:0]       stat_rd_cmds;
    logic [31:0]       stat_wr_cmds;
    logic [31:0]       stat_wr_beats;
`endif

    // master: the scheduler. slave: FIFOs plus memory controller seen as one environment.
    modport master (
        input  rd_cmd_data, rd_cmd_valid, wr_cmd_data, wr_cmd_valid, wr_data, wr_data_valid,
               mem_cmd_ready, mem_wr_ready, mem_rd_done,
        output rd_cmd_ready, wr_cmd_ready, wr_data_ready, mem_cmd_data, mem_cmd_valid,
               mem_wr_data, mem_wr_valid, mem_wr_last, rd_outstanding
`ifdef MEM_CMD_SCHED_STATS_EN
        , output stat_rd_cmds, stat_wr_cmds, stat_wr_beats
`endif
    );

    modport slave (
        output rd_cmd_data, rd_cmd_valid, wr_cmd_data, wr_cmd_valid, wr_data, wr_data_valid,
               mem_cmd_ready, mem_wr_ready, mem_rd_done,
        input  rd_cmd_ready, wr_cmd_ready, wr_data_ready, mem_cmd_data, mem_cmd_valid,
               mem_wr_data, mem_wr_valid, mem_wr_last, rd_outstanding
`ifdef MEM_CMD_SCHED_STATS_EN
        , input stat_rd_cmds, stat_wr_cmds, stat_wr_beats
`endif
    );
endinterface

// File: rtl/mem_cmd_sched.sv
// Merges read/write command streams onto one memory command port, sequences write beats, caps reads.
// Optional handshake counters are built when MEM_CMD_SCHED_STATS_EN is defined.
module mem_cmd_sched #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 13,
    parameter int DATA_W     = 32,
    parameter int MAX_RD_OUT = 4
) (
    input  logic            clk150,
    input  logic            rst,
    mem_cmd_sched_if.master bus
);
    localparam int         CMD_W  = ADDR_W + LEN_W;
    localparam int         BEAT_W = LEN_W - 1;
    localparam logic [3:0] RD_CAP = 4'(MAX_RD_OUT);

    typedef enum logic [1:0] {IDLE, CMD, WDATA} state_e;
    typedef enum logic {GNT_RD = 1'b0, GNT_WR = 1'b1} grant_e;

    state_e            state_q;
    grant_e            last_grant_q;
    logic [CMD_W:0]    cmd_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic [3:0]        rd_out_q, rd_out_d;
    logic              rd_cmd_ready_q, wr_cmd_ready_q, mem_cmd_valid_q;

    logic              rd_elig, wr_elig, grant_wr, in_wdata;
    logic              cmd_hs, rd_cmd_hs, rd_dec, beat_hs;
    logic [LEN_W:0]    wr_len_rnd;
    logic [BEAT_W-1:0] wr_beats;

    assign rd_elig    = bus.rd_cmd_valid && (rd_out_q < RD_CAP);
    assign wr_elig    = bus.wr_cmd_valid;
    // Contended grants go to whichever side did not win last time.
    assign grant_wr   = wr_elig && (!rd_elig || last_grant_q == GNT_RD);
    assign in_wdata   = (state_q == WDATA);
    assign cmd_hs     = mem_cmd_valid_q && bus.mem_cmd_ready;
    assign rd_cmd_hs  = cmd_hs && !cmd_q[CMD_W];
    assign rd_dec     = bus.mem_rd_done && (rd_out_q != 4'd0);
    assign beat_hs    = in_wdata && bus.wr_data_valid && bus.mem_wr_ready;
    assign wr_len_rnd = {1'b0, bus.wr_cmd_data[CMD_W-1:ADDR_W]} + (LEN_W+1)'(3);
    assign wr_beats   = wr_len_rnd[LEN_W:2];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk150 or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            last_grant_q    <= GNT_WR;
            cmd_q           <= '0;
            beat_cnt_q      <= '0;
            rd_cmd_ready_q  <= 1'b0;
            wr_cmd_ready_q  <= 1'b0;
            mem_cmd_valid_q <= 1'b0;
        end else begin
            rd_cmd_ready_q <= 1'b0;
            wr_cmd_ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rd_elig || wr_elig) begin
                        state_q         <= CMD;
                        mem_cmd_valid_q <= 1'b1;
                        last_grant_q    <= grant_wr ? GNT_WR : GNT_RD;
                        if (grant_wr) begin
                            cmd_q          <= {1'b1, bus.wr_cmd_data};
                            beat_cnt_q     <= wr_beats;
                            wr_cmd_ready_q <= 1'b1;
                        end else begin
                            cmd_q          <= {1'b0, bus.rd_cmd_data};
                            rd_cmd_ready_q <= 1'b1;
                        end
                    end
                end
                CMD: begin
                    if (bus.mem_cmd_ready) begin
                        mem_cmd_valid_q <= 1'b0;
                        state_q         <= (cmd_q[CMD_W] && beat_cnt_q != '0) ? WDATA : IDLE;
                    end
                end
                WDATA: begin
                    if (beat_hs) begin
                        beat_cnt_q <= beat_cnt_q - BEAT_W'(1);
                        if (beat_cnt_q == BEAT_W'(1)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        rd_out_d = rd_out_q;
        case ({rd_cmd_hs, rd_dec})
            2'b10:   rd_out_d = rd_out_q + 4'd1;
            2'b01:   rd_out_d = rd_out_q - 4'd1;
            default: rd_out_d = rd_out_q;
        endcase
    end

    always_ff @(posedge clk150 or posedge rst) begin
        if (rst) rd_out_q <= 4'd0;
        else     rd_out_q <= rd_out_d;
    end

    assign bus.rd_cmd_ready   = rd_cmd_ready_q;
    assign bus.wr_cmd_ready   = wr_cmd_ready_q;
    assign bus.mem_cmd_valid  = mem_cmd_valid_q;
    assign bus.mem_cmd_data   = cmd_q;
    // Beats only flow while a write burst is owed.
    assign bus.mem_wr_data    = in_wdata ? bus.wr_data : DATA_W'(0);
    assign bus.mem_wr_valid   = in_wdata && bus.wr_data_valid;
    assign bus.mem_wr_last    = in_wdata && (beat_cnt_q == BEAT_W'(1));
    assign bus.wr_data_ready  = in_wdata && bus.mem_wr_ready;
    assign bus.rd_outstanding = rd_out_q;

`ifdef MEM_CMD_SCHED_STATS_EN
    logic [31:0] stat_rd_q, stat_wr_q, stat_beat_q;

    always_ff @(posedge clk150 or posedge rst) begin
        if (rst) begin
            stat_rd_q   <= 32'd0;
            stat_wr_q   <= 32'd0;
            stat_beat_q <= 32'd0;
        end else begin
            if (rd_cmd_hs)                stat_rd_q   <= stat_rd_q + 32'd1;
            if (cmd_hs && cmd_q[CMD_W])   stat_wr_q   <= stat_wr_q + 32'd1;
            if (beat_hs)                  stat_beat_q <= stat_beat_q + 32'd1;
        end
    end

    assign bus.stat_rd_cmds  = stat_rd_q;
    assign bus.stat_wr_cmds  = stat_wr_q;
    assign bus.stat_wr_beats = stat_beat_q;
`endif
endmodule

// File: tb/tb_mem_cmd_sched.sv
// Scoreboard bench for mem_cmd_sched: FIFO and memory-controller models around the DUT.
// Covers reset, single read, write bursts, contention, read cap, backpressure and random traffic.
module tb_mem_cmd_sched;
    localparam int ADDR_W     = 32;
    localparam int LEN_W      = 13;
    localparam int DATA_W     = 32;
    localparam int MAX_RD_OUT = 4;
    localparam int CMD_W      = ADDR_W + LEN_W;

    logic clk150 = 1'b0;
    logic rst;
    always #5 clk150 = ~clk150;

    mem_cmd_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    mem_cmd_sched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .MAX_RD_OUT(MAX_RD_OUT)) dut (
        .clk150 (clk150),
        .rst    (rst),
        .bus    (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Upstream FIFO contents and the scoreboard of what must appear on the memory side.
    logic [CMD_W-1:0]  rd_q[$], wr_q[$], rd_exp[$], wr_exp[$];
    logic [DATA_W-1:0] wd_q[$], wd_exp[$];
    bit                grant_log[$];

    int burst_left, model_out;
    int rd_pulses, wr_pulses, rd_issued, wr_issued, beats_seen, lasts_seen, stall_seen;
    int stall_cnt, done_mode;
    bit cmd_rdy_rand, wr_rdy_toggle, wd_rand, done_pulse_req, prev_stall;
    logic [CMD_W:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int n_beats(input logic [CMD_W-1:0] c);
        return (int'(c[CMD_W-1:ADDR_W]) + 3) / 4;
    endfunction

    task automatic push_read(input logic [31:0] addr, input int len);
        logic [CMD_W-1:0] c;
        c = {LEN_W'(len), addr};
        rd_q.push_back(c);
        rd_exp.push_back(c);
    endtask

    task automatic push_write(input logic [31:0] addr, input int len);
        logic [CMD_W-1:0]  c;
        logic [DATA_W-1:0] d;
        c = {LEN_W'(len), addr};
        wr_q.push_back(c);
        wr_exp.push_back(c);
        for (int i = 0; i < n_beats(c); i++) begin
            d = $urandom;
            wd_q.push_back(d);
            wd_exp.push_back(d);
        end
    endtask

    task automatic flush_models();
        rd_q.delete(); wr_q.delete(); rd_exp.delete(); wr_exp.delete();
        wd_q.delete(); wd_exp.delete(); grant_log.delete();
        burst_left = 0; model_out = 0; prev_stall = 1'b0;
        rd_pulses = 0; wr_pulses = 0; rd_issued = 0; wr_issued = 0;
        beats_seen = 0; lasts_seen = 0; stall_cnt = 0; done_pulse_req = 1'b0;
    endtask

    task automatic drive();
        bus.rd_cmd_valid  = rd_q.size() != 0;
        bus.rd_cmd_data   = (rd_q.size() != 0) ? rd_q[0] : '0;
        bus.wr_cmd_valid  = wr_q.size() != 0;
        bus.wr_cmd_data   = (wr_q.size() != 0) ? wr_q[0] : '0;
        bus.wr_data_valid = (wd_q.size() != 0) && (!wd_rand || $urandom_range(0, 1) == 1);
        bus.wr_data       = (wd_q.size() != 0) ? wd_q[0] : '0;
        if (stall_cnt > 0) begin
            bus.mem_cmd_ready = 1'b0;
            stall_cnt--;
        end else begin
            bus.mem_cmd_ready = !cmd_rdy_rand || ($urandom_range(0, 1) == 1);
        end
        bus.mem_wr_ready = wr_rdy_toggle ? ~bus.mem_wr_ready : 1'b1;
        bus.mem_rd_done  = 1'b0;
        case (done_mode)
            1:       bus.mem_rd_done = ($urandom_range(0, 2) == 0);
            2:       bus.mem_rd_done = bus.mem_cmd_valid && !bus.mem_cmd_data[CMD_W] && bus.mem_cmd_ready;
            default: bus.mem_rd_done = 1'b0;
        endcase
        if (done_pulse_req) begin
            bus.mem_rd_done = 1'b1;
            done_pulse_req  = 1'b0;
        end
    endtask

    task automatic sample();
        logic             rd_hs, dec;
        logic [CMD_W-1:0] c;
        if (prev_stall) begin
            stall_seen++;
            check("cmd_hold_valid", bus.mem_cmd_valid, 1);
            check("cmd_hold_data", bus.mem_cmd_data, prev_data);
        end
        prev_stall = bus.mem_cmd_valid && !bus.mem_cmd_ready;
        prev_data  = bus.mem_cmd_data;
        check("rd_outstanding", bus.rd_outstanding, model_out);

        rd_hs = 1'b0;
        if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
            grant_log.push_back(bus.mem_cmd_data[CMD_W]);
            check("cmd_during_burst", burst_left, 0);
            if (bus.mem_cmd_data[CMD_W]) begin
                wr_issued++;
                check("wr_cmd_expected", wr_exp.size() != 0, 1);
                if (wr_exp.size() != 0) begin
                    c = wr_exp.pop_front();
                    check("wr_cmd_data", bus.mem_cmd_data, {1'b1, c});
                    burst_left = n_beats(c);
                end
            end else begin
                rd_issued++;
                rd_hs = 1'b1;
                check("rd_cap", model_out < MAX_RD_OUT, 1);
                check("rd_cmd_expected", rd_exp.size() != 0, 1);
                if (rd_exp.size() != 0) begin
                    c = rd_exp.pop_front();
                    check("rd_cmd_data", bus.mem_cmd_data, {1'b0, c});
                end
            end
        end

        if (bus.mem_wr_valid && bus.mem_wr_ready) begin
            beats_seen++;
            if (bus.mem_wr_last) lasts_seen++;
            check("beat_in_burst", burst_left != 0, 1);
            check("beat_last", bus.mem_wr_last, burst_left == 1);
            check("beat_expected", wd_exp.size() != 0, 1);
            if (wd_exp.size() != 0) check("beat_data", bus.mem_wr_data, wd_exp.pop_front());
            if (burst_left > 0) burst_left--;
        end

        if (bus.rd_cmd_ready) begin
            rd_pulses++;
            check("rd_ready_has_cmd", bus.rd_cmd_valid, 1);
            if (rd_q.size() != 0) void'(rd_q.pop_front());
        end
        if (bus.wr_cmd_ready) begin
            wr_pulses++;
            check("wr_ready_has_cmd", bus.wr_cmd_valid, 1);
            if (wr_q.size() != 0) void'(wr_q.pop_front());
        end
        if (bus.wr_data_ready && bus.wr_data_valid && wd_q.size() != 0) void'(wd_q.pop_front());

        dec = bus.mem_rd_done && model_out > 0;
        if (rd_hs && !dec)      model_out++;
        else if (!rd_hs && dec) model_out--;
    endtask

    task automatic cycle();
        @(posedge clk150);
        #1;
        drive();
        @(negedge clk150);
        sample();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic bit is_idle();
        return rd_q.size() == 0 && wr_q.size() == 0 && wd_q.size() == 0 && burst_left == 0 &&
               !bus.mem_cmd_valid && model_out == 0;
    endfunction

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!is_idle() && n < budget) begin
            cycle();
            n++;
        end
        check("idle_timeout", n < budget, 1);
    endtask

    task automatic check_all_zero();
        check("rst_rd_cmd_ready", bus.rd_cmd_ready, 0);
        check("rst_wr_cmd_ready", bus.wr_cmd_ready, 0);
        check("rst_wr_data_ready", bus.wr_data_ready, 0);
        check("rst_mem_cmd_valid", bus.mem_cmd_valid, 0);
        check("rst_mem_cmd_data", bus.mem_cmd_data, 0);
        check("rst_mem_wr_valid", bus.mem_wr_valid, 0);
        check("rst_mem_wr_last", bus.mem_wr_last, 0);
        check("rst_mem_wr_data", bus.mem_wr_data, 0);
        check("rst_rd_outstanding", bus.rd_outstanding, 0);
    endtask

    task automatic idle_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            check("idle_no_activity",
                  {bus.mem_cmd_valid, bus.mem_wr_valid, bus.rd_cmd_ready, bus.wr_cmd_ready}, 0);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        flush_models();
        run_cycles(2);
        rst = 1'b0;
    endtask

    task automatic check_stats();
`ifdef MEM_CMD_SCHED_STATS_EN
        check("stat_rd_cmds", bus.stat_rd_cmds, rd_issued);
        check("stat_wr_cmds", bus.stat_wr_cmds, wr_issued);
        check("stat_wr_beats", bus.stat_wr_beats, beats_seen);
`endif
    endtask

    initial begin
        int b0, l0;
        bus.rd_cmd_valid = 1'b0; bus.rd_cmd_data = '0;
        bus.wr_cmd_valid = 1'b0; bus.wr_cmd_data = '0;
        bus.wr_data_valid = 1'b0; bus.wr_data = '0;
        bus.mem_cmd_ready = 1'b0; bus.mem_wr_ready = 1'b0; bus.mem_rd_done = 1'b0;
        cmd_rdy_rand = 1'b0; wr_rdy_toggle = 1'b0; wd_rand = 1'b0; done_mode = 0;
        stall_seen = 0;
        flush_models();
        rst = 1'b1;
        #1;
        check_all_zero();
        run_cycles(2);
        rst = 1'b0;
        idle_quiet(4);
        check_stats();

        // Single read: valid one cycle after grant, one ready pulse, count follows done.
        push_read(32'h1000, 64);
        cycle();
        check("rd_grant_cycle_valid", bus.mem_cmd_valid, 0);
        cycle();
        check("rd_valid", bus.mem_cmd_valid, 1);
        check("rd_data", bus.mem_cmd_data, {1'b0, 13'd64, 32'h1000});
        check("rd_ready_pulse", bus.rd_cmd_ready, 1);
        cycle();
        check("rd_ready_single", bus.rd_cmd_ready, 0);
        check("rd_out_one", bus.rd_outstanding, 1);
        done_pulse_req = 1'b1;
        run_cycles(2);
        check("rd_out_zero", bus.rd_outstanding, 0);

        // Write len=10 -> 3 beats, last on the third only; len=0 write has no data phase.
        done_mode = 1;
        b0 = beats_seen; l0 = lasts_seen;
        push_write(32'h2000, 10);
        run_until_idle(100);
        check("w10_beats", beats_seen - b0, 3);
        check("w10_lasts", lasts_seen - l0, 1);
        b0 = beats_seen;
        push_write(32'h3000, 0);
        run_until_idle(50);
        push_read(32'h4000, 8);
        run_until_idle(50);
        check("w0_no_beats", beats_seen - b0, 0);
        check("w0_then_rd", grant_log[grant_log.size()-1], 0);

        // Contention from reset: R,W,R,W...
        apply_reset();
        done_mode = 1;
        for (int i = 0; i < 4; i++) begin
            push_read(32'h100 * i, 16);
            push_write(32'h8000 + 32'h40 * i, 4);
        end
        run_until_idle(300);
        check("contend_len", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size() && i < 8; i++) check("contend_order", grant_log[i], i % 2);

        // Read cap: four reads then only writes; simultaneous issue+done holds the count.
        apply_reset();
        done_mode = 0;
        for (int i = 0; i < 6; i++) begin
            push_read(32'hA000 + 32'h10 * i, 32);
            push_write(32'hB000 + 32'h10 * i, 8);
        end
        run_cycles(80);
        check("cap_log_len", grant_log.size(), 10);
        for (int i = 0; i < grant_log.size() && i < 10; i++)
            check("cap_order", grant_log[i], (i < 8) ? (i % 2) : 1);
        check("cap_outstanding", bus.rd_outstanding, 4);
        check("cap_rd_pending", rd_q.size(), 2);
        done_pulse_req = 1'b1;
        done_mode = 2;
        run_cycles(30);
        check("issue_done_hold", bus.rd_outstanding, 3);
        check("cap_rd_drained", rd_q.size(), 0);
        done_mode = 1;
        run_until_idle(200);

        // Backpressure: stalled command stays stable; then random ready/valid traffic.
        stall_seen = 0;
        push_read(32'h5000, 32);
        stall_cnt = 7;
        run_until_idle(100);
        check("stall_hold_cycles", stall_seen >= 5, 1);
        cmd_rdy_rand = 1'b1; wr_rdy_toggle = 1'b1; wd_rand = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) push_read($urandom, $urandom_range(1, 256));
            else                           push_write($urandom, $urandom_range(0, 40));
        end
        run_until_idle(4000);
        check("rd_ready_pulses", rd_pulses, rd_issued);
        check("wr_ready_pulses", wr_pulses, wr_issued);
        check_stats();

        // Asynchronous reset in the middle of a write burst.
        push_write(32'h6000, 40);
        for (int i = 0; i < 300 && !(burst_left > 0 && burst_left < 10); i++) cycle();
        check("burst_started", burst_left > 0 && burst_left < 10, 1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero();
        flush_models();
        cmd_rdy_rand = 1'b0; wr_rdy_toggle = 1'b0; wd_rand = 1'b0;
        run_cycles(2);
        rst = 1'b0;
        idle_quiet(8);
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
